lif_neuron_scheduler: RTL



---
 rtl/lif_neuron_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire controller: one shared update datapath serves NUM_NEURONS neurons per tick.
// Optional refractory counters are enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_scheduler #(
    parameter int NUM_NEURONS   = 4,
    parameter int POT_W         = 8,
    parameter int THRESHOLD     = 16,
    parameter int WEIGHT        = 4,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic [NUM_NEURONS-1:0]         binary_input,
    output logic [NUM_NEURONS-1:0]         spike_out,
    output logic                           spike_valid,
    input  logic                           spike_ready,
    output logic                           busy,
    output logic                           overrun,
    input  logic [$clog2(NUM_NEURONS)-1:0] dbg_sel,
    output logic [POT_W-1:0]               dbg_potential
);

    localparam int IDX_W = $clog2(NUM_NEURONS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] UPDATE = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W:0]   NN_X     = (IDX_W + 1)'(NUM_NEURONS);
    localparam logic [POT_W:0]   WEIGHT_X = (POT_W + 1)'(WEIGHT);
    localparam logic [POT_W:0]   THRESH_X = (POT_W + 1)'(THRESHOLD);
    localparam logic [POT_W:0]   POT_MAX  = {1'b0, {POT_W{1'b1}}};

    // Clamp the widened sum back into the potential range.
    function automatic logic [POT_W-1:0] sat_pot(input logic [POT_W:0] v);
        return (v > POT_MAX) ? POT_MAX[POT_W-1:0] : v[POT_W-1:0];
    endfunction

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_NEURONS-1:0] in_lat;
    logic [NUM_NEURONS-1:0] spike_vec;
    logic [POT_W-1:0]       pot [NUM_NEURONS];

    logic [POT_W-1:0] cur_pot;
    logic [POT_W-1:0] leak;
    logic [POT_W:0]   sum_p0;
    logic [POT_W-1:0] new_pot;
    logic             fire;
    logic             in_refract;

`ifdef LIF_REFRACTORY_EN
    localparam int RC_W = $clog2(REFRACT_STEPS + 1);
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT_STEPS);

    logic [RC_W-1:0] rcnt [NUM_NEURONS];
    assign in_refract = (rcnt[idx] != '0);
`else
    assign in_refract = 1'b0;
`endif

    // Shared datapath: leak, integrate, saturate, threshold for the neuron at idx.
    always_comb begin
        cur_pot = pot[idx];
        leak    = cur_pot >> LEAK_SHIFT;
        sum_p0  = {1'b0, cur_pot} - {1'b0, leak} + (in_lat[idx] ? WEIGHT_X : '0);
        new_pot = sat_pot(sum_p0);
        fire    = ({1'b0, new_pot} >= THRESH_X);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            in_lat    <= '0;
            spike_vec <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot[i] <= '0;
`ifdef LIF_REFRACTORY_EN
                rcnt[i] <= '0;
`endif
            end
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        in_lat    <= binary_input;
                        idx       <= '0;
                        spike_vec <= '0;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (tick) overrun <= 1'b1;
                    if (in_refract) begin
                        pot[idx] <= '0;
`ifdef LIF_REFRACTORY_EN
                        rcnt[idx] <= rcnt[idx] - 1'b1;
`endif
                    end else if (fire) begin
                        spike_vec[idx] <= 1'b1;
                        pot[idx]       <= '0;
`ifdef LIF_REFRACTORY_EN
                        rcnt[idx] <= RC_LOAD;
`endif
                    end else begin
                        pot[idx] <= new_pot;
                    end
                    if (idx == LAST_IDX) state <= EMIT;
                    else                 idx   <= idx + 1'b1;
                end
                EMIT: begin
                    // Ticks are refused until the vector has been consumed.
                    if (tick)        overrun <= 1'b1;
                    if (spike_ready) state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spike_out     = spike_vec;
    assign spike_valid   = (state == EMIT);
    assign busy          = (state != IDLE);
    assign dbg_potential = ({1'b0, dbg_sel} < NN_X) ? pot[dbg_sel] : '0;

endmodule
